pattern_lut_loader: RTL and testbench

Write-side companion to the ccLUT pattern lookup. It accepts a word stream from the VME configuration registers and writes the per-pattern comparator-code LUT RAMs for patterns 6..A, one pattern at a time. It tracks which patterns hold a complete table so the pattern finder treats unloaded patterns as blank (offset, bend and quality all 0). It sits between the VME register file and the dual-port LUT RAMs that the pattern finder reads on its other port.

---
 rtl/pattern_lut_pkg.sv | 45 ++++
 rtl/pattern_lut_wr_port.sv | 53 +++++
 rtl/pattern_lut_loader.sv | 112 +++++++++++
 tb/tb_pattern_lut_loader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_lut_pkg.sv
// Shared ccLUT definitions: table geometry, LUT word fields, loader FSM states and
// pattern-ID helpers. Used by both the LUT loader and the LUT reader side.
package pattern_lut_pkg;

    localparam int MXADRB = 12;
    localparam int MXDATB = 18;
    localparam int MXPIDB = 4;
    localparam int NPAT   = 5;
    localparam int PID_LO = 6;

    localparam int OFFSET_W = 4;
    localparam int BEND_W   = 5;
    localparam int QUAL_W   = 9;

    // Field view of one LUT word: offset [17:14], bend [13:9], quality [8:0].
    typedef struct packed {
        logic [OFFSET_W-1:0] offset;
        logic [BEND_W-1:0]   bend;
        logic [QUAL_W-1:0]   quality;
    } lut_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    function automatic logic pid_is_valid(input logic [MXPIDB-1:0] pid);
        return (int'(pid) >= PID_LO) && (int'(pid) < PID_LO + NPAT);
    endfunction

    // One-hot RAM select; all zeros for an ID outside PID_LO..PID_LO+NPAT-1.
    function automatic logic [NPAT-1:0] pid_to_sel(input logic [MXPIDB-1:0] pid);
        logic [NPAT-1:0] sel;
        sel = '0;
        for (int i = 0; i < NPAT; i++) begin
            if (int'(pid) == PID_LO + i) begin
                sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/pattern_lut_wr_port.sv
// Registered LUT RAM write stage plus the optional running checksum of accepted words.
// The checksum is built only when LUT_CKSUM_EN is defined; otherwise cksum is tied to 0.
module pattern_lut_wr_port
    import pattern_lut_pkg::*;
(
    input  logic              clock,
    input  logic              global_reset,
    input  logic              clr,
    input  logic              beat,
    input  logic [NPAT-1:0]   sel,
    input  logic [MXADRB-1:0] adr,
    input  logic [MXDATB-1:0] data,
    output logic              lut_we,
    output logic [NPAT-1:0]   lut_wsel,
    output logic [MXADRB-1:0] lut_wadr,
    output logic [MXDATB-1:0] lut_wdata,
    output logic [MXDATB-1:0] cksum
);

    // Address/data/select only move on a real beat so the RAM port sees stable lines between writes.
    always_ff @(posedge clock) begin
        if (global_reset) begin
            lut_we    <= 1'b0;
            lut_wsel  <= '0;
            lut_wadr  <= '0;
            lut_wdata <= '0;
        end else begin
            lut_we <= beat;
            if (beat) begin
                lut_wsel  <= sel;
                lut_wadr  <= adr;
                lut_wdata <= data;
            end
        end
    end

`ifdef LUT_CKSUM_EN
    always_ff @(posedge clock) begin
        if (global_reset) begin
            cksum <= '0;
        end else if (clr) begin
            cksum <= '0;
        end else if (beat) begin
            cksum <= {cksum[MXDATB-2:0], cksum[MXDATB-1]} ^ data;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign cksum      = '0;
`endif

endmodule

// File: rtl/pattern_lut_loader.sv
// pattern_lut_loader: streams VME configuration words into the ccLUT RAMs of patterns 6..A
// and tracks which patterns hold a complete table. Checksum option: LUT_CKSUM_EN.
module pattern_lut_loader
    import pattern_lut_pkg::*;
(
    input  logic              clock,
    input  logic              global_reset,
    input  logic              cfg_start,
    input  logic [MXPIDB-1:0] cfg_pid,
    input  logic              cfg_abort,
    input  logic [MXDATB-1:0] cfg_wr_data,
    input  logic              cfg_wr_valid,
    output logic              cfg_wr_ready,
    output logic              lut_we,
    output logic [NPAT-1:0]   lut_wsel,
    output logic [MXADRB-1:0] lut_wadr,
    output logic [MXDATB-1:0] lut_wdata,
    output logic [NPAT-1:0]   lut_valid,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [MXADRB:0]   load_cnt,
    output logic [MXDATB-1:0] load_cksum,
    output state_t            fsm_state
);

    localparam logic [MXADRB-1:0] ADR_LAST = '1;
    localparam logic [MXADRB-1:0] ADR_ONE  = {{(MXADRB-1){1'b0}}, 1'b1};
    localparam logic [MXADRB:0]   CNT_ONE  = {{MXADRB{1'b0}}, 1'b1};

    state_t            state;
    logic [NPAT-1:0]   sel;
    logic [MXADRB-1:0] adr;
    logic [NPAT-1:0]   start_sel;
    logic              start_ok;
    logic              beat;

    // Handshake: a word transfers on a cycle with cfg_wr_valid and cfg_wr_ready both high.
    // Ready is a function of state alone; cfg_abort in the same cycle cancels the transfer.
    assign cfg_wr_ready = (state == LOAD);
    assign load_busy    = (state == LOAD);
    assign beat         = cfg_wr_ready & cfg_wr_valid & ~cfg_abort;
    assign start_sel    = pid_to_sel(cfg_pid);
    assign start_ok     = (state == IDLE) & cfg_start & pid_is_valid(cfg_pid);
    assign fsm_state    = state;

    always_ff @(posedge clock) begin
        if (global_reset) begin
            state     <= IDLE;
            sel       <= '0;
            adr       <= '0;
            load_cnt  <= '0;
            load_err  <= 1'b0;
            load_done <= 1'b0;
            lut_valid <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state     <= LOAD;
                        sel       <= start_sel;
                        adr       <= '0;
                        load_cnt  <= '0;
                        load_err  <= 1'b0;
                        lut_valid <= lut_valid & ~start_sel;
                    end else if (cfg_start) begin
                        state <= ERR;
                    end
                end
                LOAD: begin
                    if (cfg_abort) begin
                        state    <= IDLE;
                        load_err <= 1'b1;
                    end else if (cfg_wr_valid) begin
                        adr      <= adr + ADR_ONE;
                        load_cnt <= load_cnt + CNT_ONE;
                        if (adr == ADR_LAST) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    lut_valid <= lut_valid | sel;
                    state     <= IDLE;
                end
                ERR: begin
                    load_err <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    pattern_lut_wr_port u_wr_port (
        .clock        (clock),
        .global_reset (global_reset),
        .clr          (start_ok),
        .beat         (beat),
        .sel          (sel),
        .adr          (adr),
        .data         (cfg_wr_data),
        .lut_we       (lut_we),
        .lut_wsel     (lut_wsel),
        .lut_wadr     (lut_wadr),
        .lut_wdata    (lut_wdata),
        .cksum        (load_cksum)
    );

endmodule

// File: tb/tb_pattern_lut_loader.sv
// Self-checking bench for pattern_lut_loader: table of load scenarios plus hand-written
// sequences for timing, flow control, reset mid-load and (with LUT_CKSUM_EN) the checksum.
module tb_pattern_lut_loader;
    import pattern_lut_pkg::*;

    localparam int SBW  = NPAT + MXADRB + MXDATB;
    localparam int NVEC = 10;

    logic              clock = 1'b0;
    logic              global_reset = 1'b0;
    logic              cfg_start = 1'b0;
    logic [MXPIDB-1:0] cfg_pid = '0;
    logic              cfg_abort = 1'b0;
    logic [MXDATB-1:0] cfg_wr_data = '0;
    logic              cfg_wr_valid = 1'b0;
    logic              cfg_wr_ready;
    logic              lut_we;
    logic [NPAT-1:0]   lut_wsel;
    logic [MXADRB-1:0] lut_wadr;
    logic [MXDATB-1:0] lut_wdata;
    logic [NPAT-1:0]   lut_valid;
    logic              load_busy;
    logic              load_done;
    logic              load_err;
    logic [MXADRB:0]   load_cnt;
    logic [MXDATB-1:0] load_cksum;
    state_t            fsm_state;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int done_count = 0;

    logic [SBW-1:0] exp_q[$];

    pattern_lut_loader dut (
        .clock        (clock),
        .global_reset (global_reset),
        .cfg_start    (cfg_start),
        .cfg_pid      (cfg_pid),
        .cfg_abort    (cfg_abort),
        .cfg_wr_data  (cfg_wr_data),
        .cfg_wr_valid (cfg_wr_valid),
        .cfg_wr_ready (cfg_wr_ready),
        .lut_we       (lut_we),
        .lut_wsel     (lut_wsel),
        .lut_wadr     (lut_wadr),
        .lut_wdata    (lut_wdata),
        .lut_valid    (lut_valid),
        .load_busy    (load_busy),
        .load_done    (load_done),
        .load_err     (load_err),
        .load_cnt     (load_cnt),
        .load_cksum   (load_cksum),
        .fsm_state    (fsm_state)
    );

    // Clock / reset
    always #5 clock = ~clock;

    task automatic do_reset();
        global_reset = 1'b1;
        repeat (2) @(negedge clock);
        global_reset = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every RAM write must match the oldest word the driver saw accepted.
    always @(negedge clock) begin
        logic [SBW-1:0] exp_w;
        if (lut_we) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                if (errors <= 20) $display("FAIL unexpected_write: got sel=%0h adr=%0h data=%0h, expected no write",
                                           lut_wsel, lut_wadr, lut_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                check("lut_write", 64'({lut_wsel, lut_wadr, lut_wdata}), 64'(exp_w));
            end
        end
        if (load_done) done_count++;
    end

    // Driver tasks (all called and returning at a falling edge)
    function automatic logic [MXDATB-1:0] word_for(input int mode, input logic [MXADRB-1:0] a);
        logic [31:0] r;
        case (mode)
            0: return {{(MXDATB-MXADRB){1'b0}}, a};
            1: return '1;
            2: return {{(MXDATB-1){1'b0}}, (a == '0)};
            default: begin
                r = $urandom;
                return r[MXDATB-1:0];
            end
        endcase
    endfunction

    task automatic start(input logic [MXPIDB-1:0] pid);
        cfg_pid   = pid;
        cfg_start = 1'b1;
        @(negedge clock);
        cfg_start = 1'b0;
    endtask

    task automatic feed(input int nbeats, input int mode, input bit toggle,
                        input logic [NPAT-1:0] sel, output int ncyc);
        int                sent;
        bit                phase;
        logic [MXADRB-1:0] a;
        logic [MXDATB-1:0] d;
        sent  = 0;
        ncyc  = 0;
        phase = 1'b0;
        while (sent < nbeats && ncyc < 20000) begin
            a = sent[MXADRB-1:0];
            d = word_for(mode, a);
            cfg_wr_valid = toggle ? ~phase : 1'b1;
            phase        = ~phase;
            cfg_wr_data  = d;
            if (cfg_wr_valid && cfg_wr_ready) begin
                exp_q.push_back({sel, a, d});
                sent++;
            end
            @(negedge clock);
            ncyc++;
        end
        cfg_wr_valid = 1'b0;
        if (sent < nbeats) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: accepted %0d beats, expected %0d", sent, nbeats);
        end
    endtask

    task automatic abort_with_beat();
        cfg_abort    = 1'b1;
        cfg_wr_valid = 1'b1;
        cfg_wr_data  = '1;
        @(negedge clock);
        cfg_abort    = 1'b0;
        cfg_wr_valid = 1'b0;
    endtask

    typedef struct {
        logic [MXPIDB-1:0] pid;
        int                beats;
        bit                abort;
        logic [NPAT-1:0]   sel;
        int                mode;
        logic              exp_err;
        logic [NPAT-1:0]   exp_valid;
        logic [MXADRB:0]   exp_cnt;
        int                exp_wr;
        int                exp_done;
    } vec_t;

    vec_t vecs[NVEC];

    initial begin
        int ncyc;
        int wr0;
        int d0;

        //            pid    beats abort sel       mode err   valid     cnt        wr    done
        vecs[0] = '{4'h7, 4096, 1'b0, 5'b00010, 0, 1'b0, 5'b00010, 13'd4096, 4096, 1};
        vecs[1] = '{4'h3, 0,    1'b0, 5'b00000, 0, 1'b1, 5'b00010, 13'd4096, 0,    0};
        vecs[2] = '{4'hA, 4096, 1'b0, 5'b10000, 3, 1'b0, 5'b10010, 13'd4096, 4096, 1};
        vecs[3] = '{4'hA, 100,  1'b1, 5'b10000, 0, 1'b1, 5'b00010, 13'd100,  100,  0};
        vecs[4] = '{4'h6, 0,    1'b1, 5'b00001, 0, 1'b1, 5'b00010, 13'd0,    0,    0};
        vecs[5] = '{4'hF, 0,    1'b0, 5'b00000, 0, 1'b1, 5'b00010, 13'd0,    0,    0};
        vecs[6] = '{4'h5, 0,    1'b0, 5'b00000, 0, 1'b1, 5'b00010, 13'd0,    0,    0};
        vecs[7] = '{4'hB, 0,    1'b0, 5'b00000, 0, 1'b1, 5'b00010, 13'd0,    0,    0};
        vecs[8] = '{4'h9, 50,   1'b1, 5'b01000, 0, 1'b1, 5'b00010, 13'd50,   50,   0};
        vecs[9] = '{4'h8, 4096, 1'b0, 5'b00100, 0, 1'b0, 5'b00110, 13'd4096, 4096, 1};

        @(negedge clock);
        do_reset();
        check("rst_state",  64'(fsm_state),    64'(IDLE));
        check("rst_we",     64'(lut_we),       64'(0));
        check("rst_wsel",   64'(lut_wsel),     64'(0));
        check("rst_wadr",   64'(lut_wadr),     64'(0));
        check("rst_wdata",  64'(lut_wdata),    64'(0));
        check("rst_valid",  64'(lut_valid),    64'(0));
        check("rst_busy",   64'(load_busy),    64'(0));
        check("rst_done",   64'(load_done),    64'(0));
        check("rst_err",    64'(load_err),     64'(0));
        check("rst_cnt",    64'(load_cnt),     64'(0));
        check("rst_cksum",  64'(load_cksum),   64'(0));
        check("rst_ready",  64'(cfg_wr_ready), 64'(0));

        for (int i = 0; i < NVEC; i++) begin
            wr0 = wr_count;
            d0  = done_count;
            start(vecs[i].pid);
            if (vecs[i].beats > 0) feed(vecs[i].beats, vecs[i].mode, 1'b0, vecs[i].sel, ncyc);
            if (vecs[i].abort) abort_with_beat();
            repeat (3) @(negedge clock);
            check($sformatf("v%0d_err", i),    64'(load_err),           64'(vecs[i].exp_err));
            check($sformatf("v%0d_valid", i),  64'(lut_valid),          64'(vecs[i].exp_valid));
            check($sformatf("v%0d_cnt", i),    64'(load_cnt),           64'(vecs[i].exp_cnt));
            check($sformatf("v%0d_writes", i), 64'(wr_count - wr0),     64'(vecs[i].exp_wr));
            check($sformatf("v%0d_dones", i),  64'(done_count - d0),    64'(vecs[i].exp_done));
            check($sformatf("v%0d_state", i),  64'(fsm_state),          64'(IDLE));
            check($sformatf("v%0d_qempty", i), 64'(exp_q.size()),       64'(0));
        end

`ifndef LUT_CKSUM_EN
        check("cksum_tied", 64'(load_cksum), 64'(0));
`endif

        // Full-rate load of pattern 7 with cycle-exact DONE and lut_valid timing.
        do_reset();
        wr0 = wr_count;
        d0  = done_count;
        start(4'h7);
        check("a_busy",  64'(load_busy),    64'(1));
        check("a_ready", 64'(cfg_wr_ready), 64'(1));
        check("a_state", 64'(fsm_state),    64'(LOAD));
        feed(4096, 0, 1'b0, 5'b00010, ncyc);
        check("a_cycles",      64'(ncyc),         64'(4096));
        check("a_done_pulse",  64'(load_done),    64'(1));
        check("a_done_state",  64'(fsm_state),    64'(DONE));
        check("a_done_ready",  64'(cfg_wr_ready), 64'(0));
        check("a_final_we",    64'(lut_we),       64'(1));
        check("a_final_adr",   64'(lut_wadr),     64'(12'hFFF));
        check("a_valid_early", 64'(lut_valid),    64'(0));
        @(negedge clock);
        check("a_done_low",    64'(load_done),    64'(0));
        check("a_valid",       64'(lut_valid),    64'(5'b00010));
        check("a_idle",        64'(fsm_state),    64'(IDLE));
        check("a_cnt",         64'(load_cnt),     64'(4096));
        repeat (2) @(negedge clock);
        check("a_writes",      64'(wr_count - wr0),   64'(4096));
        check("a_dones",       64'(done_count - d0),  64'(1));

        // Same load with cfg_wr_valid toggling: one write per accepted beat.
        wr0 = wr_count;
        start(4'h7);
        feed(4096, 0, 1'b1, 5'b00010, ncyc);
        check("b_cycles", 64'(ncyc), 64'(8191));
        repeat (3) @(negedge clock);
        check("b_writes", 64'(wr_count - wr0), 64'(4096));
        check("b_valid",  64'(lut_valid),      64'(5'b00010));

        // Invalid pid: load_err rises two cycles after cfg_start.
        wr0 = wr_count;
        start(4'h3);
        check("c_err_n1",   64'(load_err),  64'(0));
        check("c_state",    64'(fsm_state), 64'(ERR));
        @(negedge clock);
        check("c_err_n2",   64'(load_err),  64'(1));
        check("c_idle",     64'(fsm_state), 64'(IDLE));
        repeat (2) @(negedge clock);
        check("c_writes",   64'(wr_count - wr0), 64'(0));
        check("c_valid",    64'(lut_valid),      64'(5'b00010));

        // Reset asserted at beat 2000 of a pid 6 load, then a clean reload.
        start(4'h6);
        feed(2000, 0, 1'b0, 5'b00001, ncyc);
        global_reset = 1'b1;
        cfg_wr_valid = 1'b1;
        @(negedge clock);
        check("d_we",    64'(lut_we),    64'(0));
        check("d_state", 64'(fsm_state), 64'(IDLE));
        check("d_valid", 64'(lut_valid), 64'(0));
        check("d_busy",  64'(load_busy), 64'(0));
        global_reset = 1'b0;
        cfg_wr_valid = 1'b0;
        @(negedge clock);
        wr0 = wr_count;
        start(4'h6);
        feed(4096, 3, 1'b0, 5'b00001, ncyc);
        repeat (3) @(negedge clock);
        check("d_writes", 64'(wr_count - wr0), 64'(4096));
        check("d_relaod_valid", 64'(lut_valid), 64'(5'b00001));
        check("d_reload_err",   64'(load_err),  64'(0));
        check("d_qempty",       64'(exp_q.size()), 64'(0));

`ifdef LUT_CKSUM_EN
        // All-ones words cancel pairwise, so an even count ends at zero.
        start(4'h9);
        feed(4096, 1, 1'b0, 5'b01000, ncyc);
        repeat (3) @(negedge clock);
        check("e_cksum_ones", 64'(load_cksum), 64'(18'h00000));
        // One-hot seed then 4095 rotations: bit lands at 4095 mod 18 = 9.
        start(4'h9);
        feed(4096, 2, 1'b0, 5'b01000, ncyc);
        repeat (3) @(negedge clock);
        check("e_cksum_onehot", 64'(load_cksum), 64'(18'h00200));
        repeat (5) @(negedge clock);
        check("e_cksum_hold", 64'(load_cksum), 64'(18'h00200));
        // Three all-ones beats give 3FFFF; the beat cancelled by abort must not count.
        start(4'h9);
        feed(3, 1, 1'b0, 5'b01000, ncyc);
        abort_with_beat();
        repeat (3) @(negedge clock);
        check("e_cksum_abort", 64'(load_cksum), 64'(18'h3FFFF));
        check("e_abort_err",   64'(load_err),   64'(1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
